// File: rtl/reg_req_encoder.sv
// reg_req_encoder
//   Collects register requests into a pending set and issues them one index
//   at a time, in round-robin order, through a registered valid/ready stage.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous flush of pending set, output stage and pointer
//   req_load   OR-merge req_in into the pending set this cycle
//   req_in     request bits, bit k requests index k
//   out_ready  consumer accepts out_idx this cycle
//   out_valid  out_idx holds a valid index
//   out_idx    issued register index
//   pend_cnt   number of pending requests (output register not included)
//   idle       pending set empty and output stage empty
module reg_req_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        req_load,
  input  logic [31:0] req_in,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [4:0]  out_idx,
  output logic [5:0]  pend_cnt,
  output logic        idle
);

  logic [31:0] pending_q, pending_d;
  logic [4:0]  ptr_q, ptr_d;
  logic        out_valid_q, out_valid_d;
  logic [4:0]  out_idx_q, out_idx_d;

  logic [63:0] dbl_shift;
  logic [31:0] rot;
  logic [4:0]  offset;
  logic [4:0]  nxt;
  logic        found;
  logic        advance;
  logic        load_out;
  logic [31:0] clear_mask;
  logic [5:0]  cnt;

  // Rotate pending so that bit ptr lands at position 0; the lowest set bit
  // of the rotated vector is then the first hit of the wrapped scan.
  assign dbl_shift = {pending_q, pending_q} >> ptr_q;
  assign rot       = dbl_shift[31:0];
  assign found     = (pending_q != 32'd0);

  always_comb begin
    offset = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (rot[i]) offset = 5'(i);
    end
  end

  // 5-bit addition wraps naturally modulo 32.
  assign nxt      = ptr_q + offset;
  assign advance  = !out_valid_q || out_ready;
  assign load_out = advance && found;

  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_clr
      assign clear_mask[gi] = load_out && (nxt == 5'(gi));
    end
  endgenerate

  always_comb begin
    pending_d   = pending_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    if (clr) begin
      pending_d   = 32'd0;
      ptr_d       = 5'd0;
      out_valid_d = 1'b0;
    end else begin
      if (load_out) begin
        out_idx_d   = nxt;
        out_valid_d = 1'b1;
        ptr_d       = nxt + 5'd1;
      end else if (advance) begin
        out_valid_d = 1'b0;
      end
      // New requests are ORed in after the clear, so a re-request of the
      // index being issued stays pending.
      pending_d = (pending_q & ~clear_mask) | (req_load ? req_in : 32'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= 32'd0;
      ptr_q       <= 5'd0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 5'd0;
    end else begin
      pending_q   <= pending_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
    end
  end

  always_comb begin
    cnt = 6'd0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + 6'(pending_q[i]);
    end
  end

  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign pend_cnt  = cnt;
  assign idle      = !found && !out_valid_q;

endmodule

// File: tb/tb_reg_req_encoder.sv
module tb_reg_req_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clr = 1'b0;
  logic        req_load = 1'b0;
  logic [31:0] req_in = 32'd0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [4:0]  out_idx;
  logic [5:0]  pend_cnt;
  logic        idle;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  reg_req_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req_load  (req_load),
    .req_in    (req_in),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_idx   (out_idx),
    .pend_cnt  (pend_cnt),
    .idle      (idle)
  );

  // Reference model: pending set as a bit array, pointer as an integer.
  bit m_pend [32];
  int m_ptr;
  bit m_valid;
  int m_idx;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += m_pend[i];
    return c;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) m_pend[i] = 0;
    m_ptr = 0; m_valid = 0; m_idx = 0;
  endfunction

  function automatic void m_step(bit c, bit ld, logic [31:0] rq, bit rdy);
    int hit;
    if (c) begin
      for (int i = 0; i < 32; i++) m_pend[i] = 0;
      m_valid = 0; m_ptr = 0;
      return;
    end
    if (!m_valid || rdy) begin
      hit = -1;
      for (int k = 0; k < 32 && hit < 0; k++)
        if (m_pend[(m_ptr + k) % 32]) hit = (m_ptr + k) % 32;
      if (hit >= 0) begin
        m_idx = hit; m_valid = 1; m_pend[hit] = 0; m_ptr = (hit + 1) % 32;
      end else begin
        m_valid = 0;
      end
    end
    if (ld) for (int i = 0; i < 32; i++) if (rq[i]) m_pend[i] = 1;
  endfunction

  task automatic check(string name, int act, int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(string tag);
    check({tag, ".valid"}, int'(out_valid), int'(m_valid));
    check({tag, ".cnt"}, int'(pend_cnt), m_count());
    check({tag, ".idle"}, int'(idle), int'(m_count() == 0 && !m_valid));
    if (m_valid) check({tag, ".idx"}, int'(out_idx), m_idx);
  endtask

  // Drive at negedge, let the edge happen, update model, compare 1 ns later.
  task automatic step(bit c, bit ld, logic [31:0] rq, bit rdy, string tag);
    @(negedge clk);
    clr = c; req_load = ld; req_in = rq; out_ready = rdy;
    @(posedge clk);
    m_step(c, ld, rq, rdy);
    #1;
    check_model(tag);
    $display("%s clr=%0d ld=%0d req=%08h rdy=%0d -> v=%0d idx=%0d cnt=%0d idle=%0d",
             tag, c, ld, rq, rdy, out_valid, out_idx, pend_cnt, idle);
  endtask

  typedef struct {
    bit          c;
    bit          ld;
    logic [31:0] rq;
    bit          rdy;
    bit          ev;
    int          eidx;
    int          ecnt;
  } vec_t;

  vec_t tbl [26];

  initial begin
    // Basic
    tbl[0]  = '{0, 1, 32'h8000_0001, 1, 0, 0, 2};
    tbl[1]  = '{0, 0, 32'h0, 1, 1, 0, 1};
    tbl[2]  = '{0, 0, 32'h0, 1, 1, 31, 0};
    tbl[3]  = '{0, 0, 32'h0, 1, 0, 0, 0};
    // Round robin: issue 5 (ptr=6), then bits 3 and 7 -> 7, 3; ptr ends at 4
    tbl[4]  = '{0, 1, 32'h0000_0020, 1, 0, 0, 1};
    tbl[5]  = '{0, 0, 32'h0, 1, 1, 5, 0};
    tbl[6]  = '{0, 1, 32'h0000_0088, 1, 0, 0, 2};
    tbl[7]  = '{0, 0, 32'h0, 1, 1, 7, 1};
    tbl[8]  = '{0, 0, 32'h0, 1, 1, 3, 0};
    tbl[9]  = '{0, 0, 32'h0, 1, 0, 0, 0};
    // ptr=4 shows up as 5 being chosen before 3
    tbl[10] = '{0, 1, 32'h0000_0028, 1, 0, 0, 2};
    tbl[11] = '{0, 0, 32'h0, 1, 1, 5, 1};
    tbl[12] = '{0, 0, 32'h0, 1, 1, 3, 0};
    tbl[13] = '{0, 0, 32'h0, 1, 0, 0, 0};
    // Backpressure
    tbl[14] = '{0, 1, 32'h0000_0006, 0, 0, 0, 2};
    tbl[15] = '{0, 0, 32'h0, 0, 1, 1, 1};
    tbl[16] = '{0, 0, 32'h0, 0, 1, 1, 1};
    tbl[17] = '{0, 0, 32'h0, 0, 1, 1, 1};
    tbl[18] = '{0, 0, 32'h0, 0, 1, 1, 1};
    tbl[19] = '{0, 0, 32'h0, 0, 1, 1, 1};
    tbl[20] = '{0, 0, 32'h0, 1, 1, 2, 0};
    tbl[21] = '{0, 0, 32'h0, 1, 0, 0, 0};
    // clr with pending and a held index; the load in the clr cycle is dropped
    tbl[22] = '{0, 1, 32'h0000_00F0, 0, 0, 0, 4};
    tbl[23] = '{0, 0, 32'h0, 0, 1, 4, 3};
    tbl[24] = '{1, 1, 32'h0000_FFFF, 1, 0, 0, 0};
    tbl[25] = '{0, 0, 32'h0, 1, 0, 0, 0};

    m_reset();
    #2;
    check("reset.valid", int'(out_valid), 0);
    check("reset.cnt", int'(pend_cnt), 0);
    check("reset.idle", int'(idle), 1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven directed vectors (model kept in step alongside)
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      clr = tbl[i].c; req_load = tbl[i].ld; req_in = tbl[i].rq; out_ready = tbl[i].rdy;
      @(posedge clk);
      m_step(tbl[i].c, tbl[i].ld, tbl[i].rq, tbl[i].rdy);
      #1;
      check($sformatf("tbl%0d.valid", i), int'(out_valid), int'(tbl[i].ev));
      check($sformatf("tbl%0d.cnt", i), int'(pend_cnt), tbl[i].ecnt);
      check($sformatf("tbl%0d.idle", i), int'(idle), int'(tbl[i].ecnt == 0 && !tbl[i].ev));
      if (tbl[i].ev) check($sformatf("tbl%0d.idx", i), int'(out_idx), tbl[i].eidx);
      $display("tbl%0d req=%08h rdy=%0d -> v=%0d idx=%0d cnt=%0d idle=%0d",
               i, tbl[i].rq, tbl[i].rdy, out_valid, out_idx, pend_cnt, idle);
    end

    // Full set: 0..31 on consecutive cycles, count falling by one each cycle
    step(0, 1, 32'hFFFF_FFFF, 1, "full.load");
    check("full.cnt32", int'(pend_cnt), 32);
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 32'h0, 1, "full");
      check($sformatf("full.idx%0d", i), int'(out_idx), i);
      check($sformatf("full.cnt%0d", i), int'(pend_cnt), 31 - i);
    end
    step(0, 0, 32'h0, 1, "full.end");

    // Re-request the index held in the output register
    step(0, 1, 32'h0000_0200, 0, "rereq.load");
    step(0, 0, 32'h0, 0, "rereq.issue");
    step(0, 1, 32'h0000_0200, 0, "rereq.again");
    check("rereq.cnt", int'(pend_cnt), 1);
    step(0, 0, 32'h0, 1, "rereq.second");
    check("rereq.idx2", int'(out_idx), 9);
    // Re-request of the index in the very cycle it is issued (set wins)
    step(0, 1, 32'h0000_0400, 1, "setwin.load");
    step(0, 1, 32'h0000_0400, 1, "setwin.issue");
    step(0, 0, 32'h0, 1, "setwin.second");
    check("setwin.idx", int'(out_idx), 10);
    step(0, 0, 32'h0, 1, "setwin.end");

    // Async reset between edges during a full-set drain
    step(0, 1, 32'hFFFF_FFFF, 1, "arst.load");
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 1, "arst.drain");
    #2 rst = 1'b1;
    #1;
    check("arst.valid", int'(out_valid), 0);
    check("arst.cnt", int'(pend_cnt), 0);
    check("arst.idle", int'(idle), 1);
    $display("arst mid-cycle -> v=%0d cnt=%0d idle=%0d", out_valid, pend_cnt, idle);
    #1 rst = 1'b0;
    m_reset();
    step(0, 1, 32'h8000_0001, 1, "arst.reload");
    step(0, 0, 32'h0, 1, "arst.first");
    check("arst.first_idx", int'(out_idx), 0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bit          c, ld, rdy;
      logic [31:0] rq;
      c   = ($urandom_range(0, 99) < 2);
      ld  = ($urandom_range(0, 99) < 30);
      rdy = ($urandom_range(0, 99) < 65);
      rq  = $urandom() & $urandom();
      if ($urandom_range(0, 3) == 0) rq = 32'd1 << $urandom_range(0, 31);
      step(c, ld, rq, rdy, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
